// File: rtl/ge_prog_sequencer_if.sv
// ----------------------------------------------------------------------------
// GeProgSequencer bus interface
//
// Purpose:
//    Bundles the program-load port, the operand handshake and the result
//    handshake of ge_prog_sequencer into one interface. The sequencer
//    connects through the slave modport. Whatever drives programs and
//    operands, and consumes results, connects through the master modport.
//
// Signals (direction given from the sequencer's side):
//    i_progWe     in   program-memory write strobe (honoured only when idle)
//    i_progAddr   in   program-memory write address, log2(DEPTH) bits
//    i_progData   in   instruction {op[1:0], dst[1:0], src[2:0]}
//    i_progLen    in   instruction count, log2(DEPTH)+1 bits, saturates at DEPTH
//    i_inValid    in   operand handshake valid
//    o_inReady    out  operand handshake ready (idle only)
//    i_a1..i_b0   in   16-bit operands, sampled when a run is accepted
//    o_outValid   out  result handshake valid (done only)
//    i_outReady   in   result handshake ready
//    o_y3..o_y0   out  16-bit working registers r3..r0
//    o_busy       out  high while executing or holding a result
// ----------------------------------------------------------------------------
interface ge_prog_sequencer_if #(
   parameter int DEPTH = 32
);

   localparam int AW = $clog2(DEPTH);

   logic          i_progWe;
   logic [AW-1:0] i_progAddr;
   logic [6:0]    i_progData;
   logic [AW:0]   i_progLen;

   logic          i_inValid;
   logic          o_inReady;
   logic [15:0]   i_a1;
   logic [15:0]   i_a0;
   logic [15:0]   i_b1;
   logic [15:0]   i_b0;

   logic          o_outValid;
   logic          i_outReady;
   logic [15:0]   o_y3;
   logic [15:0]   o_y2;
   logic [15:0]   o_y1;
   logic [15:0]   o_y0;

   logic          o_busy;

   // The sequencer itself: consumes program/operands, produces results.
   modport slave (
      input  i_progWe,
      input  i_progAddr,
      input  i_progData,
      input  i_progLen,
      input  i_inValid,
      output o_inReady,
      input  i_a1,
      input  i_a0,
      input  i_b1,
      input  i_b0,
      output o_outValid,
      input  i_outReady,
      output o_y3,
      output o_y2,
      output o_y1,
      output o_y0,
      output o_busy
   );

   // The agent that loads programs, launches runs and collects results.
   modport master (
      output i_progWe,
      output i_progAddr,
      output i_progData,
      output i_progLen,
      output i_inValid,
      input  o_inReady,
      output i_a1,
      output i_a0,
      output i_b1,
      output i_b0,
      input  o_outValid,
      output i_outReady,
      input  o_y3,
      input  o_y2,
      input  o_y1,
      input  o_y0,
      input  o_busy
   );

endinterface

// File: rtl/ge_prog_sequencer.sv
// ----------------------------------------------------------------------------
// ge_prog_sequencer
//
// Purpose:
//    A tiny programmable bit-logic engine. A program of up to DEPTH
//    instructions is loaded into an internal memory while the block is
//    idle. Each accepted run loads four working registers from the
//    operands, executes the first len instructions (one per cycle), and
//    then presents the four registers as the result until it is taken.
//
//    Instruction format {op[1:0], dst[1:0], src[2:0]}:
//       src 0..3 -> working register r0..r3 (current value)
//       src 4..7 -> latched operand a0, a1, b0, b1
//       op 00 OR, 01 XOR, 10 AND, 11 logical NOT of src (result 0 or 1)
//
// Ports:
//    clk   in   sole clock, rising edge
//    rst   in   synchronous active-high reset
//    bus   ge_prog_sequencer_if.slave, see the interface file for members
// ----------------------------------------------------------------------------
module ge_prog_sequencer #(
   parameter int DEPTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   ge_prog_sequencer_if.slave      bus
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]   DEPTH_LEN = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PC_ONE    = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } seqState_t;

   seqState_t     r_state;
   seqState_t     w_nextState;

   logic [6:0]    r_mem [DEPTH];

   logic [AW-1:0] r_pc;
   logic [AW:0]   r_len;
   logic [15:0]   r_regs [4];
   logic [15:0]   r_ia0;
   logic [15:0]   r_ia1;
   logic [15:0]   r_ib0;
   logic [15:0]   r_ib1;

   logic          w_accept;
   logic [AW:0]   w_lenSat;
   logic          w_lastInstr;
   logic [6:0]    w_instr;
   logic [1:0]    w_op;
   logic [1:0]    w_dst;
   logic [2:0]    w_src;
   logic [15:0]   w_srcVal;
   logic [15:0]   w_dstVal;
   logic [15:0]   w_result;

   // A run is accepted only in IDLE. The requested length is clamped to
   // the memory depth here so that pc can never run past the last entry.
   always_comb begin
      w_accept = bus.i_inValid & (r_state == S_IDLE);
      w_lenSat = bus.i_progLen;
      if (bus.i_progLen > DEPTH_LEN) begin
         w_lenSat = DEPTH_LEN;
      end
   end

   // The instruction at pc is the last one of the run when pc reaches
   // len-1. Only meaningful in EXEC, where len is always at least one.
   always_comb begin
      w_lastInstr = ({1'b0, r_pc} == (r_len - LEN_ONE));
   end

   // FSM state register. Reset always lands in IDLE, which also aborts
   // any run in flight so its result is never offered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next-state logic. A zero-length run skips EXEC entirely; a
   // result is held in DONE until the consumer raises out_ready.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_lenSat == '0) begin
                  w_nextState = S_DONE;
               end else begin
                  w_nextState = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            if (w_lastInstr) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.i_outReady) begin
               w_nextState = S_IDLE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // FSM outputs depend on the state alone, so ready/valid/busy are clean
   // registered-state decodes. Leaving DONE goes to IDLE first, so
   // in_ready never rises in the same cycle a result is taken.
   always_comb begin
      bus.o_inReady  = 1'b0;
      bus.o_outValid = 1'b0;
      bus.o_busy     = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.o_inReady = 1'b1;
         end
         S_EXEC: begin
            bus.o_busy = 1'b1;
         end
         S_DONE: begin
            bus.o_outValid = 1'b1;
            bus.o_busy     = 1'b1;
         end
         default: begin
            bus.o_inReady = 1'b0;
         end
      endcase
   end

   // Program memory: one write port, one asynchronous read port. Writes
   // are honoured only while idle, so the program can never change under
   // a running sequence. The memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (bus.i_progWe && (r_state == S_IDLE)) begin
         r_mem[bus.i_progAddr] <= bus.i_progData;
      end
   end

   // Instruction fetch and field split.
   always_comb begin
      w_instr = r_mem[r_pc];
      w_op    = w_instr[6:5];
      w_dst   = w_instr[4:3];
      w_src   = w_instr[2:0];
   end

   // Operand selection. Register sources read the current register file,
   // which already holds every earlier instruction's result; when dst and
   // src name the same register this is naturally the pre-instruction
   // value, since the write lands only at the clock edge.
   always_comb begin
      w_dstVal = r_regs[w_dst];
      w_srcVal = r_regs[w_src[1:0]];
      case (w_src)
         3'd4:    w_srcVal = r_ia0;
         3'd5:    w_srcVal = r_ia1;
         3'd6:    w_srcVal = r_ib0;
         3'd7:    w_srcVal = r_ib1;
         default: w_srcVal = r_regs[w_src[1:0]];
      endcase
   end

   // The ALU. The NOT opcode is a logical, not bitwise, negation: any
   // non-zero source yields zero, a zero source yields one.
   always_comb begin
      w_result = w_dstVal;
      case (w_op)
         2'b00:   w_result = w_dstVal | w_srcVal;
         2'b01:   w_result = w_dstVal ^ w_srcVal;
         2'b10:   w_result = w_dstVal & w_srcVal;
         2'b11:   w_result = (w_srcVal == 16'h0000) ? 16'h0001 : 16'h0000;
         default: w_result = w_dstVal;
      endcase
   end

   // Datapath registers. On accept the operands are captured twice: once
   // as the working registers and once as read-only copies that later
   // instructions can still reference, so the operand ports are free to
   // change for the rest of the run. pc stops on the last instruction
   // instead of stepping past it. Outside a run nothing here moves, so
   // the results stay visible in DONE and afterwards in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc   <= '0;
         r_len  <= '0;
         r_regs <= '{default: '0};
         r_ia0  <= '0;
         r_ia1  <= '0;
         r_ib0  <= '0;
         r_ib1  <= '0;
      end else if (w_accept) begin
         r_pc      <= '0;
         r_len     <= w_lenSat;
         r_ia0     <= bus.i_a0;
         r_ia1     <= bus.i_a1;
         r_ib0     <= bus.i_b0;
         r_ib1     <= bus.i_b1;
         r_regs[0] <= bus.i_a0;
         r_regs[1] <= bus.i_a1;
         r_regs[2] <= bus.i_b0;
         r_regs[3] <= bus.i_b1;
      end else if (r_state == S_EXEC) begin
         r_regs[w_dst] <= w_result;
         if (!w_lastInstr) begin
            r_pc <= r_pc + PC_ONE;
         end
      end
   end

   // The result outputs are the working registers themselves.
   assign bus.o_y0 = r_regs[0];
   assign bus.o_y1 = r_regs[1];
   assign bus.o_y2 = r_regs[2];
   assign bus.o_y3 = r_regs[3];

endmodule

// File: tb/tb_ge_prog_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ge_prog_sequencer
//
// Scoreboarded bench for ge_prog_sequencer. The stimulus process loads
// programs and launches runs; for each launch it computes the expected
// result with a plain instruction-by-instruction interpreter over a shadow
// copy of the program and queues it with the expected latency. A separate
// monitor pops the queue whenever a result appears and also watches that
// a held result stays stable.
// ----------------------------------------------------------------------------
module tb_ge_prog_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   typedef struct {
      logic [63:0] y;
      int          lat;
   } expT;

   logic clk;
   logic rst;

   int   checks;
   int   errors;
   int   cycle;
   expT  expQ [$];

   logic [6:0] progModel [DEPTH];

   ge_prog_sequencer_if #(.DEPTH(DEPTH)) bus ();

   ge_prog_sequencer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and reports it when it does not match.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference interpreter: run the first len instructions of the shadow
   // program over four registers seeded from the operands.
   function automatic logic [63:0] modelRun(input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] b0, input logic [15:0] b1,
                                            input int len);
      logic [15:0] r   [4];
      logic [15:0] opd [4];
      logic [15:0] s;
      logic [6:0]  ins;
      int          d;
      int          sIdx;
      r[0] = a0;  r[1] = a1;  r[2] = b0;  r[3] = b1;
      opd[0] = a0; opd[1] = a1; opd[2] = b0; opd[3] = b1;
      for (int i = 0; i < len; i++) begin
         ins  = progModel[i];
         d    = int'(ins[4:3]);
         sIdx = int'(ins[2:0]);
         s    = (sIdx < 4) ? r[sIdx] : opd[sIdx - 4];
         case (ins[6:5])
            2'b00:   r[d] = r[d] | s;
            2'b01:   r[d] = r[d] ^ s;
            2'b10:   r[d] = r[d] & s;
            default: r[d] = (s == 16'h0000) ? 16'h0001 : 16'h0000;
         endcase
      end
      return {r[3], r[2], r[1], r[0]};
   endfunction

   function automatic logic [63:0] yVec();
      return {bus.o_y3, bus.o_y2, bus.o_y1, bus.o_y0};
   endfunction

   // Program write; the shadow copy follows only when the write is made
   // while the sequencer is idle and therefore must land.
   task automatic writeProg(input int addr, input logic [6:0] data, input bit inIdle);
      @(posedge clk); #1;
      bus.i_progWe   = 1'b1;
      bus.i_progAddr = AW'(addr);
      bus.i_progData = data;
      @(posedge clk); #1;
      bus.i_progWe   = 1'b0;
      if (inIdle) progModel[addr] = data;
   endtask

   // Launch one run and queue its expected result. Returns just after the
   // accepting edge, with the operand ports already scrambled.
   task automatic applyStimulus(input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] b0, input logic [15:0] b1,
                                input logic [AW:0] len, output logic [63:0] expY);
      expT e;
      int  effLen;
      bit  seen;
      effLen = (int'(len) > DEPTH) ? DEPTH : int'(len);
      e.y    = modelRun(a0, a1, b0, b1, effLen);
      e.lat  = effLen + 1;
      expY   = e.y;
      expQ.push_back(e);
      @(posedge clk); #1;
      bus.i_a0 = a0; bus.i_a1 = a1; bus.i_b0 = b0; bus.i_b1 = b1;
      bus.i_progLen = len;
      bus.i_inValid = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (bus.o_inReady) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("acceptSeen", 64'(seen), 64'd1);
      @(posedge clk); #1;
      bus.i_inValid = 1'b0;
      bus.i_a0 = 16'($urandom); bus.i_a1 = 16'($urandom);
      bus.i_b0 = 16'($urandom); bus.i_b1 = 16'($urandom);
      bus.i_progLen = (AW+1)'($urandom);
   endtask

   // Wait for the result, hold it for `hold` cycles, take it, then check
   // the block is idle again and still shows the result.
   task automatic waitDone(input int hold, input logic [63:0] expY);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 3 * DEPTH + 10; t++) begin
         @(negedge clk);
         if (bus.o_outValid) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("doneSeen", 64'(seen), 64'd1);
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      bus.i_outReady = 1'b1;
      @(posedge clk); #1;
      bus.i_outReady = 1'b0;
      @(negedge clk);
      checkOutput("inReadyAfterDone", 64'(bus.o_inReady), 64'd1);
      checkOutput("outValidAfterDone", 64'(bus.o_outValid), 64'd0);
      checkOutput("idleHold", yVec(), expY);
   endtask

   // Monitor: pairs every rising out_valid with the oldest queued
   // expectation (value and accept-to-valid latency), and checks that a
   // held result stays put with in_ready low and busy high.
   initial begin : monitor
      int          acceptCycle;
      bit          wasValid;
      logic [63:0] held;
      expT         e;
      acceptCycle = 0;
      wasValid    = 1'b0;
      held        = '0;
      cycle       = 0;
      forever begin
         @(negedge clk);
         cycle++;
         if (rst) begin
            wasValid = 1'b0;
         end else begin
            if (bus.i_inValid && bus.o_inReady) acceptCycle = cycle;
            if (bus.o_outValid) begin
               checkOutput("doneInReady", 64'(bus.o_inReady), 64'd0);
               checkOutput("doneBusy", 64'(bus.o_busy), 64'd1);
               if (!wasValid) begin
                  if (expQ.size() == 0) begin
                     checkOutput("unexpectedOutValid", 64'd1, 64'd0);
                  end else begin
                     e = expQ.pop_front();
                     checkOutput("result", yVec(), e.y);
                     checkOutput("latency", 64'(cycle - acceptCycle), 64'(e.lat));
                  end
                  held = yVec();
               end else begin
                  checkOutput("holdStable", yVec(), held);
               end
            end
            wasValid = bus.o_outValid;
         end
      end
   end

   // Main stimulus.
   initial begin : stimulus
      logic [63:0] expY;
      logic [63:0] expOld;
      logic [6:0]  d;
      logic [15:0] op [4];
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.i_progWe = 1'b0; bus.i_progAddr = '0; bus.i_progData = '0;
      bus.i_progLen = '0;  bus.i_inValid = 1'b0; bus.i_outReady = 1'b0;
      bus.i_a0 = '0; bus.i_a1 = '0; bus.i_b0 = '0; bus.i_b1 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("resetInReady", 64'(bus.o_inReady), 64'd1);
      checkOutput("resetOutValid", 64'(bus.o_outValid), 64'd0);
      checkOutput("resetBusy", 64'(bus.o_busy), 64'd0);
      checkOutput("resetY", yVec(), 64'd0);

      for (int a = 0; a < DEPTH; a++) begin
         d = 7'($urandom);
         writeProg(a, d, 1'b1);
      end

      // XOR of r0 with ib0, single instruction.
      writeProg(0, 7'b01_00_110, 1'b1);
      applyStimulus(16'h00FF, 16'h1234, 16'h0F0F, 16'hABCD, 1, expY);
      waitDone(0, expY);

      // Zero-length run just echoes the operands.
      applyStimulus(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, expY);
      waitDone(1, expY);

      // Logical NOT of a zero and of a non-zero operand.
      writeProg(0, 7'b11_11_110, 1'b1);
      writeProg(1, 7'b11_10_100, 1'b1);
      applyStimulus(16'h0005, 16'hBEEF, 16'h0000, 16'hCAFE, 2, expY);
      waitDone(0, expY);

      // Result held for five cycles before it is taken.
      applyStimulus(16'h0A0A, 16'h5050, 16'h00F0, 16'h0F00, 4, expY);
      waitDone(5, expY);

      // Over-long length saturates at DEPTH.
      applyStimulus(16'h8001, 16'h7FFE, 16'hC3C3, 16'h3C3C, (AW+1)'(2 * DEPTH - 1), expY);
      @(negedge clk);
      checkOutput("execBusy", 64'(bus.o_busy), 64'd1);
      checkOutput("execInReady", 64'(bus.o_inReady), 64'd0);
      waitDone(2, expY);

      // Writes while running are dropped; the same writes made while idle land.
      writeProg(0, 7'b00_00_111, 1'b1);
      writeProg(1, 7'b10_01_101, 1'b1);
      writeProg(2, 7'b01_10_000, 1'b1);
      writeProg(3, 7'b00_11_010, 1'b1);
      applyStimulus(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 4, expOld);
      bus.i_progWe = 1'b1;
      for (int a = 0; a < 3; a++) begin
         bus.i_progAddr = AW'(a);
         bus.i_progData = 7'b01_01_100;
         @(posedge clk); #1;
      end
      bus.i_progWe = 1'b0;
      waitDone(0, expOld);
      applyStimulus(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 4, expY);
      waitDone(0, expY);
      writeProg(0, 7'b01_01_100, 1'b1);
      applyStimulus(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 4, expY);
      waitDone(0, expY);

      // Reset in the third EXEC cycle of a ten-instruction run.
      applyStimulus(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0001, 10, expY);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      expQ.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abortInReady", 64'(bus.o_inReady), 64'd1);
      checkOutput("abortOutValid", 64'(bus.o_outValid), 64'd0);
      checkOutput("abortBusy", 64'(bus.o_busy), 64'd0);
      checkOutput("abortY", yVec(), 64'd0);
      applyStimulus(16'h0102, 16'h0304, 16'h0506, 16'h0708, 0, expY);
      waitDone(0, expY);

      // Randomised programs, operands, lengths and hold times.
      for (int run = 0; run < 24; run++) begin
         for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
            d = 7'($urandom);
            writeProg(int'($urandom_range(0, DEPTH - 1)), d, 1'b1);
         end
         for (int k = 0; k < 4; k++) begin
            op[k] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         end
         applyStimulus(op[0], op[1], op[2], op[3],
                       (AW+1)'($urandom_range(0, 2 * DEPTH - 1)), expY);
         waitDone(int'($urandom_range(0, 3)), expY);
      end

      repeat (3) @(negedge clk);
      checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ge_prog_sequencer.md
GE_PROG_SEQUENCER -- requirements
Module: ge_prog_sequencer

Interface
REQ-001 Parameter DEPTH, default 32, program memory entries (power of two, 2..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 prog_we  input  1  program-memory write strobe.
REQ-005 prog_addr  input  log2(DEPTH)  write address.
REQ-006 prog_data  input  7  instruction: [6:5] op, [4:3] dst, [2:0] src.
REQ-007 prog_len  input  log2(DEPTH)+1  instruction count, sampled at accept.
REQ-008 in_valid / in_ready  input / output  1 each  operand handshake.
REQ-009 a1, a0, b1, b0  input  16 each  operands, sampled at accept.
REQ-010 out_valid / out_ready  output / input  1 each  result handshake.
REQ-011 y3, y2, y1, y0  output  16 each  results, equal to r3, r2, r1, r0.
REQ-012 busy  output  1  high in EXEC and DONE.

Function
REQ-013 State machine shall be IDLE -> EXEC -> DONE -> IDLE; one state register.
REQ-014 in_ready shall be 1 only in IDLE; accept = in_valid & in_ready.
REQ-015 On accept: latch operands into ia0/ia1/ib0/ib1; load r0=a0, r1=a1, r2=b0, r3=b1; pc=0; latch len=min(prog_len, DEPTH).
REQ-016 After accept, len=0 shall go to DONE; otherwise to EXEC.
REQ-017 In EXEC, exactly one instruction mem[pc] per cycle; pc increments; after instruction len-1, go to DONE.
REQ-018 src decode: 0..3 = r0..r3 (current value, including earlier updates), 4 = ia0, 5 = ia1, 6 = ib0, 7 = ib1.
REQ-019 op decode: 00 rd = rd | s; 01 rd = rd ^ s; 10 rd = rd & s; 11 rd = (s == 0) ? 16'h0001 : 16'h0000 (logical NOT, zero-extended).
REQ-020 dst equal to src register shall use the pre-instruction value as operand.
REQ-021 Operand ports shall be ignored after accept; only the latched copies are used.
REQ-022 out_valid shall be 1 only in DONE; y3..y0 shall stay stable while out_valid=1 and out_ready=0.
REQ-023 DONE with out_ready=1 shall return to IDLE next cycle; in_ready is not asserted in that same cycle.
REQ-024 Latency: for accept at edge T, out_valid shall rise at edge T+1+len (len=0 gives T+1).
REQ-025 prog_we shall write mem[prog_addr] only when the state is IDLE; writes in EXEC or DONE shall be dropped silently.
REQ-026 A write to the address executing in the same cycle is impossible by REQ-025; the memory has one write port and one read port, with asynchronous read.
REQ-027 prog_len > DEPTH shall saturate to DEPTH; pc shall never wrap.
REQ-028 y outputs shall hold their last values in IDLE until the next accept.

Reset
REQ-029 rst shall force state=IDLE, pc=0, r0..r3=0, latched operands=0, out_valid=0, busy=0; in_ready=1 from the first cycle after reset.
REQ-030 rst shall not clear program memory; contents are undefined until written.
REQ-031 rst asserted mid-EXEC or in DONE shall abort the run; the result is never presented.

Verification
REQ-032 Program mem[0]=op01,dst0,src6 with len=1; a0=0x00FF, a1=0x1234, b0=0x0F0F, b1=0xABCD -> out_valid 2 cycles after accept, y0=0x0FF0, y1=0x1234, y2=0x0F0F, y3=0xABCD.
REQ-033 With len=0 and any operands -> out_valid 1 cycle after accept; y0..y3 = a0, a1, b0, b1.
REQ-034 Program mem[0]=op11,dst3,src6; mem[1]=op11,dst2,src4; len=2; b0=0x0000, a0=0x0005 -> y3=0x0001, y2=0x0000, out_valid at T+3.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, y stable, in_ready=0; set out_ready=1 -> IDLE next cycle.
REQ-036 Pulse prog_we during EXEC to the address being executed -> the current and later results match the pre-write program; the same write repeated in IDLE takes effect.
REQ-037 Assert rst at EXEC cycle 3 of a len=10 run -> no out_valid; in_ready=1 the next cycle; a new run with len=0 completes correctly.
